asc_field_writer: RTL
=====================

Name: asc_field_writer

Overview:
- Write-side counterpart to ascending-range part-select reads.
- Holds a register declared [LO:HI], ascending, so index LO is the MSB.
- Accepts queued field-write commands in indexed "+:" or "-:" form and applies one per cycle, with per-bit masking and out-of-range clipping.
- Exposes the flattened register and a registered field readback so benches can cross-check writes against ascending-select reads.

Parameters:
- LO, 19, lowest (MSB) index of the register.
- HI, 50, highest (LSB) index of the register; N = HI-LO+1 = 32.
- FW, 8, maximum field width per command.
- DEPTH, 4, command FIFO depth (power of two, >= 2).
- IW, 7, width of the unsigned base index; must satisfy 2**IW > HI.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; high when count < DEPTH.
- cmd_dir  in  1  0 = "+:" (r[b : b+len-1]); 1 = "-:" (r[b-len+1 : b]).
- cmd_base  in  IW  absolute index b.
- cmd_len  in  $clog2(FW+1)  field width; 0 = no-op.
- cmd_data  in  FW  field value, right-aligned; data[len-1] lands at the lowest index of the field.
- load_valid  in  1  whole-register load this cycle.
- load_data  in  N  load_data[N-1] goes to r[LO].
- rd_dir, rd_base, rd_len  in  1/IW/$clog2(FW+1)  readback select, same encoding as cmd_*.
- rd_data  out  FW  registered readback, right-aligned.
- q  out  N  flattened register; q[HI-k] = r[k].
- pending  out  $clog2(DEPTH+1)  FIFO occupancy.
- busy  out  1  pending != 0.
- err  out  1  sticky clip/overlength error.
- err_clr  in  1  clears err.

Behaviour:
- Reset (async assert, sync release): q=0, FIFO empty, pending=0, busy=0, err=0, rd_data=0, cmd_ready=1.
- Handshake:
  - A command is accepted on an edge with cmd_valid&&cmd_ready.
  - Inputs may change freely when cmd_ready is low.
  - No combinational path from cmd_valid to cmd_ready.
- Application:
  - The FIFO head is applied on each edge where the FIFO is non-empty and load_valid is low.
  - A command accepted at edge E into an empty FIFO updates q at edge E+1.
  - Throughput is one command per cycle.
- Push and pop on the same edge: both happen; pending is unchanged. When full, a pop on that edge does not raise cmd_ready in the same cycle.
- Field mapping:
  - For bit i in 0..len-1, the target index is t = lowfield + (len-1-i), where lowfield = b for "+:" and lowfield = b-len+1 for "-:".
  - Index arithmetic is signed, IW+2 bits wide; no wrap-around.
  - Bits with t<LO or t>HI are dropped and set err. The in-range bits of the same command are still written.
  - Bits outside the field are never modified.
- Lengths:
  - cmd_len > FW is clamped to FW and sets err.
  - len 0 consumes a FIFO slot, changes nothing and does not set err.
- load_valid:
  - Loads q on that edge.
  - The head command is held and applied on the next edge without load_valid.
  - Load ordering is not serialised against queued commands.
- err:
  - Set has priority over err_clr on the same edge.
  - Stays set until err_clr.
- Readback:
  - rd_data is registered, 1-cycle latency, using the same mapping as writes.
  - Out-of-range bits and bits i >= len read 0.
  - Readback samples q before any write on the same edge.
- Reset mid-operation discards all queued commands immediately.

Test Plan:
- Load 32'h12345678 (LO=19, HI=50); read "+:" b=47 len 4 -> rd_data=8'h08. Read "+:" b=27 len 4 -> 8'h03. Read "-:" b=26 len 4 -> 8'h02.
- q=0.
  - Write "+:" b=27 len 4 data 3 -> q=32'h00300000 one cycle after acceptance.
  - Then write "-:" b=26 len 4 data 2 -> q=32'h02300000.
  - err=0 throughout.
- Clipping:
  - q=0; write "+:" b=48 len 4 data 4'hF -> q=32'h00000007 and err=1.
  - err_clr -> err=0.
  - Write "-:" b=20 len 4 data 4'hF -> q[31:30]=2'b11, err=1.
- Back-pressure: hold load_valid for 6 cycles while pushing 5 commands -> cmd_ready drops after 4 accepts, pending=4, no command lost. After load drops, all 5 apply in order and the final q matches the model.
- Masking: load 32'hFFFFFFFF; write "+:" b=19 len 8 data 8'h00 -> q=32'h00FFFFFF. A len 0 command leaves q unchanged.
- Reset mid-operation: assert rst_n=0 with pending=3 -> q=0, pending=0 asynchronously; no queued write is applied after release.

Source files
------------

// File: rtl/asc_field_writer_if.sv
// Command handshake bundle for asc_field_writer: one field write per transfer,
// accepted on an edge where cmd_valid and cmd_ready are both high.
interface asc_field_writer_if #(
  parameter int IW = 7,
  parameter int FW = 8
);
  localparam int LW = $clog2(FW + 1);

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_dir;
  logic [IW-1:0] cmd_base;
  logic [LW-1:0] cmd_len;
  logic [FW-1:0] cmd_data;

  modport master (
    output cmd_valid, cmd_dir, cmd_base, cmd_len, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_base, cmd_len, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/asc_field_writer.sv
// Ascending-range [LO:HI] register with queued "+:"/"-:" field writes, whole
// register loads, clipping error flag and a registered field readback port.
module asc_field_writer #(
  parameter  int LO    = 19,
  parameter  int HI    = 50,
  parameter  int FW    = 8,
  parameter  int DEPTH = 4,
  parameter  int IW    = 7,
  localparam int N     = HI - LO + 1,
  localparam int LW    = $clog2(FW + 1),
  localparam int PW    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  asc_field_writer_if.slave       cmd,
  input  logic                    load_valid,
  input  logic [N-1:0]            load_data,
  input  logic                    rd_dir,
  input  logic [IW-1:0]           rd_base,
  input  logic [LW-1:0]           rd_len,
  output logic [FW-1:0]           rd_data,
  output logic [N-1:0]            q,
  output logic [PW-1:0]           pending,
  output logic                    busy,
  output logic                    err,
  input  logic                    err_clr
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW  = IW + 2;
  localparam int NIW = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [SW-1:0] LO_S = SW'(LO);
  localparam logic signed [SW-1:0] HI_S = SW'(HI);

  typedef struct packed {
    logic          dir;
    logic [IW-1:0] base;
    logic [LW-1:0] len;
    logic [FW-1:0] data;
  } cmd_t;

  // Lengths beyond the field capacity saturate to FW.
  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
    return (len > LW'(FW)) ? LW'(FW) : len;
  endfunction

  // Field bit i lands at index lowfield + (len-1-i); result is {in_range, q position}.
  // Signed arithmetic keeps "-:" fields below index 0 from wrapping into range.
  function automatic logic [NIW:0] map_bit(input logic          dir,
                                           input logic [IW-1:0] base,
                                           input logic [LW-1:0] len,
                                           input int            i);
    logic signed [SW-1:0] lowf;
    logic signed [SW-1:0] t;
    logic [NIW:0]         res;
    lowf = $signed({2'b00, base});
    if (dir) lowf = lowf - $signed(SW'(len)) + SW'(1);
    t = lowf + $signed(SW'(len)) - SW'(1) - SW'(i);
    res[NIW]       = (t >= LO_S) && (t <= HI_S);
    res[NIW-1:0]   = NIW'(HI_S - t);
    return res;
  endfunction

  cmd_t          fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic          push;
  cmd_t          cmd_in;

  assign cmd.cmd_ready = (count < PW'(DEPTH));
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign pending       = count;
  assign busy          = (count != '0);

  assign cmd_in.dir  = cmd.cmd_dir;
  assign cmd_in.base = cmd.cmd_base;
  assign cmd_in.len  = cmd.cmd_len;
  assign cmd_in.data = cmd.cmd_data;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cmd_in;
  end

  // ---- p0: decode FIFO head into a write mask for this edge ----
  logic          vld_p0;
  cmd_t          head_p0;
  logic [LW-1:0] len_p0;
  logic [N-1:0]  wmask_p0;
  logic [N-1:0]  wval_p0;
  logic          clip_p0;
  logic          over_p0;
  logic [NIW:0]  mw_p0;

  assign vld_p0  = (count != '0) && !load_valid;
  assign head_p0 = fifo_mem[rd_ptr];

  always_comb begin
    wmask_p0 = '0;
    wval_p0  = '0;
    clip_p0  = 1'b0;
    mw_p0    = '0;
    len_p0   = clamp_len(head_p0.len);
    over_p0  = (head_p0.len > LW'(FW));
    for (int i = 0; i < FW; i++) begin
      if (i < int'(len_p0)) begin
        mw_p0 = map_bit(head_p0.dir, head_p0.base, len_p0, i);
        if (mw_p0[NIW]) begin
          wmask_p0[mw_p0[NIW-1:0]] = 1'b1;
          wval_p0[mw_p0[NIW-1:0]]  = head_p0.data[i];
        end else begin
          clip_p0 = 1'b1;
        end
      end
    end
  end

  // Readback gathers from q as it stands before this edge's write.
  logic [LW-1:0] rlen_p0;
  logic [FW-1:0] rd_nxt_p0;
  logic [NIW:0]  mr_p0;

  always_comb begin
    rd_nxt_p0 = '0;
    mr_p0     = '0;
    rlen_p0   = clamp_len(rd_len);
    for (int i = 0; i < FW; i++) begin
      if (i < int'(rlen_p0)) begin
        mr_p0 = map_bit(rd_dir, rd_base, rlen_p0, i);
        if (mr_p0[NIW]) rd_nxt_p0[i] = q[mr_p0[NIW-1:0]];
      end
    end
  end

  // ---- p1: register, FIFO pointers, error flag, readback ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      q       <= '0;
      err     <= 1'b0;
      rd_data <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (vld_p0) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, vld_p0})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (load_valid)  q <= load_data;
      else if (vld_p0) q <= (q & ~wmask_p0) | wval_p0;
      if (vld_p0 && (clip_p0 || over_p0)) err <= 1'b1;
      else if (err_clr)                   err <= 1'b0;
      rd_data <= rd_nxt_p0;
    end
  end

endmodule
